// File: rtl/z_sched_pkg.sv
// Shared defaults and FSM encoding for the z-vector stream scheduler.
package z_sched_pkg;

    localparam int NUM_BANKS = 4;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 16;
    localparam int BANK_W    = $clog2(NUM_BANKS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        READ,
        CAPTURE,
        PAIR,
        DONE
    } state_t;

endpackage

// File: rtl/z_stream_scheduler_bank_fill_tracker.sv
// Per-bank saturating fill counters; a drain clear combined with a same-cycle
// fill strobe leaves the count at one.
module bank_fill_tracker #(
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic [NUM_BANKS-1:0] inc,
    input  logic [NUM_BANKS-1:0] clr,
    output logic [NUM_BANKS-1:0] bank_full
);

    logic [CNT_W-1:0] count [NUM_BANKS];

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (clr[i]) begin
                    count[i] <= inc[i] ? CNT_W'(1) : '0;
                end else if (inc[i] && count[i] != CNT_W'(DEPTH)) begin
                    count[i] <= count[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_full[i] = (count[i] == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/z_stream_scheduler.sv
// Streams the z caches bank by bank into the MAC, pairing each z with an m.
// Define ZSTREAM_PERF_CNT_EN to add the stall_cycles performance counter.
module z_stream_scheduler
    import z_sched_pkg::*;
#(
    parameter int NUM_BANKS = z_sched_pkg::NUM_BANKS,
    parameter int DEPTH     = z_sched_pkg::DEPTH,
    parameter int ADDR_W    = z_sched_pkg::ADDR_W,
    parameter int DATA_W    = z_sched_pkg::DATA_W,
    localparam int BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 en,
    input  logic                 start,
    input  logic [NUM_BANKS-1:0] bank_fill,
    output logic                 wr_block,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic                 rd_en,
    output logic [BANK_W-1:0]    rd_bank,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 m_req,
    input  logic                 m_ready,
    input  logic [DATA_W-1:0]    m_data,
    output logic                 mac_valid,
    input  logic                 mac_ready,
    output logic [DATA_W-1:0]    mac_z,
    output logic [DATA_W-1:0]    mac_m,
    output logic                 mac_last_vec,
    output logic                 mac_last,
    output logic                 busy,
    output logic                 done
`ifdef ZSTREAM_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    state_t               state, state_next;
    logic                 m_held, rd_pending;
    logic                 m_take, accept, last_addr, last_bank, start_ok;
    logic [NUM_BANKS-1:0] fill_inc, fill_clr;

    // The cache port is shared, so writers are held off for the read cycle only.
    always_comb begin
        rd_en        = en && (state == READ);
        wr_block     = rd_en;
        m_req        = en && (state == CAPTURE || state == PAIR) && !m_held;
        m_take       = m_req && m_ready;
        mac_valid    = (state == PAIR) && m_held;
        accept       = en && mac_valid && mac_ready;
        last_addr    = (rd_addr == ADDR_W'(DEPTH - 1));
        last_bank    = (rd_bank == BANK_W'(NUM_BANKS - 1));
        mac_last_vec = mac_valid && last_addr;
        mac_last     = mac_last_vec && last_bank;
        busy         = (state != IDLE);
        done         = en && (state == DONE);
        start_ok     = en && (state == IDLE) && start;
        fill_inc     = (en && !wr_block) ? bank_fill : '0;
        fill_clr     = '0;
        if (accept && last_addr) begin
            fill_clr[rd_bank] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (en) begin
            case (state)
                IDLE:      if (start) state_next = WAIT_FILL;
                WAIT_FILL: if (bank_full[rd_bank]) state_next = READ;
                READ:      state_next = CAPTURE;
                CAPTURE:   state_next = PAIR;
                PAIR: begin
                    if (accept) begin
                        if (!last_addr)     state_next = READ;
                        else if (last_bank) state_next = DONE;
                        else                state_next = WAIT_FILL;
                    end
                end
                DONE:      state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Read data is captured one cycle after any issued read, even if en has since dropped.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state      <= IDLE;
            rd_bank    <= '0;
            rd_addr    <= '0;
            mac_z      <= '0;
            mac_m      <= '0;
            m_held     <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_next;
            rd_pending <= rd_en;
            if (rd_pending) begin
                mac_z <= rd_data;
            end
            if (m_take) begin
                mac_m  <= m_data;
                m_held <= 1'b1;
            end
            if (accept) begin
                m_held <= 1'b0;
                if (last_addr) begin
                    rd_addr <= '0;
                    rd_bank <= rd_bank + 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
            if (start_ok) begin
                rd_bank <= '0;
                rd_addr <= '0;
            end
        end
    end

    bank_fill_tracker #(
        .NUM_BANKS(NUM_BANKS),
        .DEPTH    (DEPTH)
    ) u_fill (
        .clock    (clock),
        .clear_n  (clear_n),
        .inc      (fill_inc),
        .clr      (fill_clr),
        .bank_full(bank_full)
    );

`ifdef ZSTREAM_PERF_CNT_EN
    logic stall_now;

    always_comb begin
        stall_now = busy && en && ((mac_valid && !mac_ready) || (m_req && !m_ready) ||
                                   (state == WAIT_FILL));
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if (stall_now && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_z_stream_scheduler.sv
// Directed bench for z_stream_scheduler with a cache model and an m source.
module tb_z_stream_scheduler;

    logic        clock = 1'b0;
    logic        clear_n, en, start;
    logic [3:0]  bank_fill;
    logic        wr_block;
    logic [3:0]  bank_full;
    logic        rd_en;
    logic [1:0]  rd_bank;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        m_req, m_ready;
    logic [15:0] m_data;
    logic        mac_valid, mac_ready;
    logic [15:0] mac_z, mac_m;
    logic        mac_last_vec, mac_last, busy, done;
`ifdef ZSTREAM_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_base;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int m_idx = 0;
    int exp_bank, exp_addr, exp_pairs;
    int last_acc_cyc, first_acc_cyc;

    z_stream_scheduler dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .en          (en),
        .start       (start),
        .bank_fill   (bank_fill),
        .wr_block    (wr_block),
        .bank_full   (bank_full),
        .rd_en       (rd_en),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .m_req       (m_req),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .mac_valid   (mac_valid),
        .mac_ready   (mac_ready),
        .mac_z       (mac_z),
        .mac_m       (mac_m),
        .mac_last_vec(mac_last_vec),
        .mac_last    (mac_last),
        .busy        (busy),
        .done        (done)
`ifdef ZSTREAM_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [15:0] pat(input logic [1:0] b, input logic [3:0] a);
        return {4'hA, 2'b00, b, 4'h0, a};
    endfunction

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Cache model: one-cycle read latency, contents fixed by bank/address.
    always @(posedge clock) if (rd_en) rd_data <= pat(rd_bank, rd_addr);

    always @(posedge clock) begin
        if (!clear_n)                m_idx <= 0;
        else if (m_req && m_ready)   m_idx <= m_idx + 1;
    end

    assign m_data = 16'h5000 + 16'(m_idx);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        clear_n   = 1'b0;
        en        = 1'b1;
        start     = 1'b0;
        bank_fill = '0;
        m_ready   = 1'b1;
        mac_ready = 1'b1;
        repeat (2) @(negedge clock);
        clear_n   = 1'b1;
        exp_bank  = 0;
        exp_addr  = 0;
        exp_pairs = 0;
    endtask

    task automatic apply_fill(input int b, input int n);
        repeat (n) begin
            bank_fill = 4'(1 << b);
            @(negedge clock);
        end
        bank_fill = '0;
    endtask

    task automatic apply_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, " busy"},      busy,      0);
        check_output({tag, " done"},      done,      0);
        check_output({tag, " mac_valid"}, mac_valid, 0);
        check_output({tag, " rd_en"},     rd_en,     0);
        check_output({tag, " wr_block"},  wr_block,  0);
        check_output({tag, " m_req"},     m_req,     0);
        check_output({tag, " mac_z"},     mac_z,     0);
        check_output({tag, " mac_m"},     mac_m,     0);
        check_output({tag, " bank_full"}, bank_full, 0);
        check_output({tag, " rd_bank"},   rd_bank,   0);
        check_output({tag, " rd_addr"},   rd_addr,   0);
        check_output({tag, " last"},      {mac_last_vec, mac_last}, 0);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!mac_valid && k < 60) begin
            @(negedge clock);
            k++;
        end
        if (!mac_valid) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL wait_valid observed=0 expected=1");
        end
    endtask

    task automatic check_pair();
        string t;
        t = $sformatf("pair b%0d a%0d", exp_bank, exp_addr);
        check_output({t, " mac_z"},   mac_z,   pat(2'(exp_bank), 4'(exp_addr)));
        check_output({t, " mac_m"},   mac_m,   16'h5000 + 16'(exp_pairs));
        check_output({t, " rd_bank"}, rd_bank, exp_bank);
        check_output({t, " rd_addr"}, rd_addr, exp_addr);
        check_output({t, " last_vec"}, mac_last_vec, (exp_addr == 15));
        check_output({t, " last"},    mac_last, (exp_addr == 15 && exp_bank == 3));
        if (mac_ready) begin
            last_acc_cyc = cyc;
            exp_pairs++;
            if (exp_addr == 15) begin
                exp_addr = 0;
                exp_bank = (exp_bank + 1) % 4;
            end else begin
                exp_addr++;
            end
        end
    endtask

    task automatic stream_pairs(input int n);
        repeat (n) begin
            wait_valid();
            check_pair();
            @(negedge clock);
        end
    endtask

    task automatic check_frozen(input string tag);
        check_output({tag, " rd_en"},     rd_en,     0);
        check_output({tag, " m_req"},     m_req,     0);
        check_output({tag, " wr_block"},  wr_block,  0);
        check_output({tag, " mac_valid"}, mac_valid, 1);
        check_output({tag, " mac_z"},     mac_z,     pat(2'd0, 4'd7));
        check_output({tag, " mac_m"},     mac_m,     16'h5000 + 16'(exp_pairs));
        check_output({tag, " rd_addr"},   rd_addr,   7);
        check_output({tag, " busy"},      busy,      1);
    endtask

    initial begin
        int k;

        // Reset state
        reset_dut();
        check_idle("reset");

        // Full pass over four pre-filled banks
        for (int b = 0; b < 4; b++) apply_fill(b, 16);
        check_output("all banks full", bank_full, 4'hF);
        apply_start();
        stream_pairs(1);
        first_acc_cyc = last_acc_cyc;
        stream_pairs(63);
        check_output("pass cycles", last_acc_cyc - first_acc_cyc, 192);
        check_output("done pulse", done, 1);
        check_output("busy in done", busy, 1);
        @(negedge clock);
        check_output("done after", done, 0);
        check_output("busy after", busy, 0);
        check_output("banks drained", bank_full, 0);

        // Only bank 0 full: stall in WAIT_FILL, resume when bank 1 fills
        reset_dut();
        apply_fill(0, 16);
        apply_start();
        stream_pairs(16);
        check_output("wait busy", busy, 1);
        check_output("wait bank_full", bank_full, 0);
        check_output("wait rd_bank", rd_bank, 1);
        check_output("wait rd_addr", rd_addr, 0);
        repeat (3) begin
            @(negedge clock);
            check_output("wait no valid", {mac_valid, rd_en}, 0);
        end
        apply_fill(1, 16);
        stream_pairs(5);

        // Hold mac_ready low for 5 cycles mid-vector
        wait_valid();
        mac_ready = 1'b0;
`ifdef ZSTREAM_PERF_CNT_EN
        stall_base = stall_cycles;
`endif
        repeat (5) begin
            @(negedge clock);
            check_output("stall valid", mac_valid, 1);
            check_output("stall mac_z", mac_z, pat(2'd1, 4'd5));
            check_output("stall mac_m", mac_m, 16'h5000 + 16'(exp_pairs));
            check_output("stall rd_addr", rd_addr, 5);
        end
`ifdef ZSTREAM_PERF_CNT_EN
        check_output("stall_cycles delta", stall_cycles - stall_base, 5);
`endif
        mac_ready = 1'b1;
        check_pair();
        @(negedge clock);

        // Dropped strobe under wr_block, saturation of an idle bank
        reset_dut();
        apply_fill(0, 16);
        apply_fill(1, 15);
        apply_fill(2, 17);
        check_output("saturate bank_full", bank_full, 4'b0101);
        apply_start();
        k = 0;
        while (!rd_en && k < 20) begin
            @(negedge clock);
            k++;
        end
        check_output("read wr_block", wr_block, 1);
        bank_fill = 4'b0010;
        @(negedge clock);
        bank_fill = '0;
        check_output("blocked strobe dropped", bank_full, 4'b0101);
        stream_pairs(1);
        @(negedge clock);
        check_output("capture wr_block", wr_block, 0);
        bank_fill = 4'b0010;
        @(negedge clock);
        bank_fill = '0;
        check_output("unblocked strobe taken", bank_full, 4'b0111);
        stream_pairs(6);

        // en low for 3 cycles in PAIR, then reset mid-pass
        wait_valid();
        en = 1'b0;
        check_frozen("en0 c0");
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check_frozen($sformatf("en0 c%0d", i));
        end
        en      = 1'b1;
        clear_n = 1'b0;
        @(negedge clock);
        check_idle("midpass reset");
        clear_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check_output("no done after reset", {done, busy}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
